// File: rtl/prog_mem_loader.sv
// prog_mem_loader
// ---------------
// Writable 16x8 program memory with a byte-stream load controller for the
// 4-bit CPU. A host streams a 16-byte program over a valid/ready byte port
// while the CPU is held halted. When the image is complete, the controller
// releases the CPU with a one-cycle restart pulse. The CPU then fetches
// through a combinational 4-bit-address / 8-bit-data read port.
//
// Optional feature macro: PROG_MEM_LOADER_CHECKSUM_EN
//   defined   : a 17th byte must equal the 8-bit sum of the 16 program bytes.
//               A mismatch parks the controller in ERR with ld_err=1.
//   undefined : the 16th byte goes straight to RUN, and ld_err is tied to 0.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   cpu_addr     CPU fetch address (PC)
//   cpu_data     instruction at cpu_addr; 8'h00 unless running
//   cpu_halt     1 = CPU must not advance PC/registers
//   cpu_restart  one-cycle pulse when the CPU is released
//   ld_start     begin (or abort and restart) a load session
//   ld_valid     ld_data carries a byte
//   ld_data      program or checksum byte
//   ld_ready     controller accepts a byte this cycle
//   ld_count     bytes accepted in the current session
//   ld_err       last session failed its checksum

module prog_mem_loader (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] cpu_addr,
  output logic [7:0] cpu_data,
  output logic       cpu_halt,
  output logic       cpu_restart,
  input  logic       ld_start,
  input  logic       ld_valid,
  input  logic [7:0] ld_data,
  output logic       ld_ready,
  output logic [4:0] ld_count,
  output logic       ld_err
);

`ifdef PROG_MEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    ST_HALT,
    ST_LOAD,
    ST_CHECK,
    ST_RUN,
    ST_ERR
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_HALT,
    ST_LOAD,
    ST_RUN,
    ST_ERR
  } state_t;
`endif

  state_t     state;
  state_t     next_state;
  logic [7:0] mem [16];
  logic [4:0] count_q;
  logic       restart_q;
  logic       session_clear;
  logic       mem_we;
  logic       enter_run;

`ifdef PROG_MEM_LOADER_CHECKSUM_EN
  logic [7:0] sum_q;
  logic       err_q;
  logic       check_hs;
  logic       enter_err;
`endif

  // State register. Reset parks the controller in HALT with the CPU held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_HALT;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and control decode. A handshake only counts when ld_start is
  // low, because ld_start in LOAD/CHECK aborts the session and the byte
  // offered in the same cycle has to be thrown away. ld_ready and cpu_halt
  // depend only on the state so the host never sees a combinational path
  // from its own inputs.
  always_comb begin
    next_state    = state;
    ld_ready      = 1'b0;
    cpu_halt      = 1'b1;
    session_clear = 1'b0;
    mem_we        = 1'b0;
    enter_run     = 1'b0;
`ifdef PROG_MEM_LOADER_CHECKSUM_EN
    check_hs      = 1'b0;
    enter_err     = 1'b0;
`endif
    case (state)
      ST_HALT, ST_ERR: begin
        if (ld_start) begin
          next_state    = ST_LOAD;
          session_clear = 1'b1;
        end
      end
      ST_RUN: begin
        cpu_halt = 1'b0;
        if (ld_start) begin
          next_state    = ST_LOAD;
          session_clear = 1'b1;
        end
      end
      ST_LOAD: begin
        ld_ready = 1'b1;
        if (ld_start) begin
          next_state    = ST_LOAD;
          session_clear = 1'b1;
        end else if (ld_valid) begin
          mem_we = 1'b1;
          if (count_q[3:0] == 4'd15) begin
`ifdef PROG_MEM_LOADER_CHECKSUM_EN
            next_state = ST_CHECK;
`else
            next_state = ST_RUN;
            enter_run  = 1'b1;
`endif
          end
        end
      end
`ifdef PROG_MEM_LOADER_CHECKSUM_EN
      ST_CHECK: begin
        ld_ready = 1'b1;
        if (ld_start) begin
          next_state    = ST_LOAD;
          session_clear = 1'b1;
        end else if (ld_valid) begin
          check_hs = 1'b1;
          if (ld_data == sum_q) begin
            next_state = ST_RUN;
            enter_run  = 1'b1;
          end else begin
            next_state = ST_ERR;
            enter_err  = 1'b1;
          end
        end
      end
`endif
      default: begin
        next_state = ST_HALT;
      end
    endcase
  end

  // Memory, byte counter, running sum and flags. The reset clears the image
  // too, so a session interrupted by reset cannot leave stale bytes behind.
  // The restart pulse is registered from the transition into RUN, which makes
  // it line up with the first cycle cpu_halt is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        mem[i] <= 8'h00;
      end
      count_q   <= 5'd0;
      restart_q <= 1'b0;
`ifdef PROG_MEM_LOADER_CHECKSUM_EN
      sum_q     <= 8'h00;
      err_q     <= 1'b0;
`endif
    end else begin
      restart_q <= enter_run;
      if (session_clear) begin
        count_q <= 5'd0;
`ifdef PROG_MEM_LOADER_CHECKSUM_EN
        sum_q   <= 8'h00;
        err_q   <= 1'b0;
`endif
      end else if (mem_we) begin
        mem[count_q[3:0]] <= ld_data;
        count_q           <= count_q + 5'd1;
`ifdef PROG_MEM_LOADER_CHECKSUM_EN
        sum_q             <= sum_q + ld_data;
`endif
      end
`ifdef PROG_MEM_LOADER_CHECKSUM_EN
      else if (check_hs) begin
        count_q <= count_q + 5'd1;
        if (enter_err) begin
          err_q <= 1'b1;
        end
      end
`endif
    end
  end

  // CPU read port. It is gated to zero whenever the CPU is not running, so a
  // half-written image never reaches the fetch path.
  always_comb begin
    cpu_data = 8'h00;
    if (state == ST_RUN) begin
      cpu_data = mem[cpu_addr];
    end
  end

  assign cpu_restart = restart_q;
  assign ld_count    = count_q;
`ifdef PROG_MEM_LOADER_CHECKSUM_EN
  assign ld_err      = err_q;
`else
  assign ld_err      = 1'b0;
`endif

endmodule

// File: doc/prog_mem_loader.md
# prog_mem_loader

Writable 16×8 program memory with a load controller for the 4-bit CPU, replacing the fixed instruction ROM. A host streams a 16-byte program over a valid/ready byte port while the CPU is held halted. On completion the controller releases the CPU with a one-cycle restart pulse. The CPU then fetches from the same combinational 4-bit-address / 8-bit-data read port used by the ROM.

## Interface
Parameters: none (depth 16, width 8 fixed by the ISA).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cpu_addr  in  4  CPU fetch address (PC)
- cpu_data  out  8  instruction at cpu_addr; combinational
- cpu_halt  out  1  1 = CPU must not advance PC/registers
- cpu_restart  out  1  one-cycle pulse; CPU resets PC and registers to 0
- ld_start  in  1  begin a new load session (level sampled each cycle)
- ld_valid  in  1  ld_data carries a byte
- ld_data  in  8  program or checksum byte
- ld_ready  out  1  controller accepts a byte this cycle
- ld_count  out  5  bytes accepted in the current session (0–17)
- ld_err  out  1  last session failed checksum

## Operation
- States: HALT (reset), LOAD, CHECK (checksum build only), RUN, ERR.
- HALT: cpu_halt=1, ld_ready=0. ld_start → LOAD.
- LOAD: ld_ready=1. On handshake (ld_valid & ld_ready & !ld_start):
  - mem[ld_count[3:0]] ← ld_data.
  - sum ← sum + ld_data (8-bit, wraps mod 256).
  - ld_count increments.
  - The 16th byte (ld_count 15→16) transitions to CHECK, or to RUN without checksum.
- CHECK: ld_ready=1. Handshake compares ld_data with sum and increments ld_count to 17.
  - Equal → RUN.
  - Unequal → ERR with ld_err=1.
  - Memory is not written in CHECK.
- RUN: cpu_halt=0, ld_ready=0, cpu_data=mem[cpu_addr]. ld_start → LOAD.
- ERR: cpu_halt=1, ld_ready=0, ld_err=1. ld_start → LOAD.
- Entering LOAD from any state clears ld_count, sum and ld_err. Memory contents are retained until overwritten.
- ld_start asserted in LOAD or CHECK aborts the session and restarts LOAD at count 0. A simultaneous byte is discarded, not written.
- cpu_data=8'h00 in every state other than RUN.
- Extra bytes are never accepted: ld_ready is 0 outside LOAD/CHECK.
- Reset values:
  - state=HALT, mem all 8'h00, sum=0, ld_count=0.
  - cpu_halt=1, cpu_restart=0, ld_ready=0, ld_err=0, cpu_data=8'h00.
- Reset mid-session: immediate return to reset values. The partially loaded image is cleared.

## Timing
- All state, memory, count and sum updates occur on the rising edge of clk. rst_n acts asynchronously.
- ld_ready and cpu_halt are decoded from the state register, not from inputs.
- A byte written at edge N is readable on cpu_data after edge N (no further latency). It is visible only once in RUN.
- Final handshake at edge N enters RUN at N. cpu_halt falls and cpu_restart=1 for exactly the cycle following edge N. cpu_restart is 0 from edge N+1 onward.
- Minimum session length: 16 cycles, or 17 with checksum, for back-to-back ld_valid.
- ld_valid may drop at any time; the controller waits indefinitely.

## Configuration
- PROG_MEM_LOADER_CHECKSUM_EN defined:
  - CHECK state exists.
  - A session is 16 program bytes + 1 checksum byte (8-bit sum of the 16 bytes).
  - Mismatch → ERR.
- Undefined:
  - No CHECK state or sum register.
  - ld_err is tied to 0.
  - The 16th byte goes LOAD → RUN directly and ld_count stops at 16.

## Test plan
- Reset, then no stimulus → cpu_halt=1, ld_ready=0, cpu_data=8'h00 for every cpu_addr, ld_count=0.
- Load bytes 8'h00..8'h0F back-to-back, plus checksum 8'h78 when checksum is enabled → RUN.
  - cpu_restart is high for exactly 1 cycle.
  - cpu_data=addr for all 16 addresses.
  - ld_count=16 (17 with checksum).
- Checksum enabled: load the same 16 bytes with checksum 8'h77 → ERR, ld_err=1, cpu_halt=1, cpu_data=8'h00.
  - A subsequent ld_start clears ld_err and sets ld_ready=1.
- During LOAD at ld_count=5: assert ld_start with ld_valid=1, ld_data=8'hAA.
  - ld_count returns to 0 and mem[5] is unchanged.
  - Then load 16 × 8'hFF (checksum 8'hF0) → RUN, all reads 8'hFF.
- Throttled ld_valid (random gaps up to 5 cycles) with bytes 8'hB7,8'h01,... → the image matches byte-for-byte; state does not change while ld_valid=0.
- Assert rst_n=0 for 1 cycle at ld_count=9 → all outputs return to reset values immediately; the memory reads 8'h00 after a fresh load of zeros.
